// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-byte adder: adds two 8*NBYTES-bit operands one byte per clock, LSB first.
// Optional MULTIBYTE_ADD_SEQ_SUB_EN adds a `sub` port selecting A-B instead of A+B.
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [IW+2:0] off;
    logic [8:0]    byte_sum;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        off      = {idx_q, 3'b000};
        byte_sum = {1'b0, a_q[off +: 8]} + {1'b0, b_q[off +: 8]}
                 + {8'd0, carry_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    idx_d   = '0;
                    state_d = ADD;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
                    // Subtraction as A + ~B + 1; cout then means no borrow.
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
`else
                    b_d     = b;
                    carry_d = 1'b0;
`endif
                end
            end
            ADD: begin
                res_d[off +: 8] = byte_sum[7:0];
                carry_d         = byte_sum[8];
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                sum_d   = res_q;
                cout_d  = carry_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq (NBYTES=4); sub vectors run when MULTIBYTE_ADD_SEQ_SUB_EN is set.
module tb_multibyte_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;

    int errors = 0;
    int checks = 0;

    multibyte_add_seq #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for its done pulse.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int bcnt);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    int          lat;
    int          bcnt;
    int          ndone;
    int          first_done;
    int          second_done;
    int          hold_bad;
    logic [31:0] s_cap;
    logic        c_cap;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        tick();

        do_op(32'h0000_00FF, 32'h0000_0001, lat, bcnt);
        chk("carry_lat", 64'(lat), 64'd5);
        chk("carry_busy_cycles", 64'(bcnt), 64'd5);
        chk("carry_sum", 64'(sum), 64'h0000_0100);
        chk("carry_cout", 64'(cout), 64'd0);
        chk("busy_low_at_done", 64'(busy), 64'd0);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);

        do_op(32'hFFFF_FFFF, 32'h0000_0001, lat, bcnt);
        chk("wrap_sum", 64'(sum), 64'h0000_0000);
        chk("wrap_cout", 64'(cout), 64'd1);
        tick();

        do_op(32'h1234_5678, 32'h1111_1111, lat, bcnt);
        chk("plain_sum", 64'(sum), 64'h2345_6789);
        chk("plain_cout", 64'(cout), 64'd0);
        tick();

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("max_sum", 64'(sum), 64'hFFFF_FFFE);
        chk("max_cout", 64'(cout), 64'd1);
        tick();

        do_op(32'h80FF_0080, 32'h8001_0080, lat, bcnt);
        chk("mixed_sum", 64'(sum), 64'h0100_0100);
        chk("mixed_cout", 64'(cout), 64'd1);
        tick();

        // Operands change and start pulses while the add is running.
        a     = 32'h0101_0101;
        b     = 32'h0202_0202;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        s_cap = '0;
        c_cap = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                s_cap = sum;
                c_cap = cout;
            end
            tick();
        end
        chk("busy_start_ignored_ndone", 64'(ndone), 64'd1);
        chk("busy_start_ignored_sum", 64'(s_cap), 64'h0303_0303);
        chk("busy_start_ignored_cout", 64'(c_cap), 64'd0);

        // Held start: back-to-back operations.
        a           = 32'h0000_0001;
        b           = 32'h0000_0001;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        chk("held_start_period", 64'(second_done - first_done), 64'd6);
        for (int i = 0; i < 10; i++) tick();
        chk("held_start_sum", 64'(sum), 64'h0000_0002);

        // Reset on the third ADD cycle aborts the operation.
        a     = 32'h0000_0010;
        b     = 32'h0000_0020;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        do_op(32'h0000_0002, 32'h0000_0003, lat, bcnt);
        chk("after_abort_sum", 64'(sum), 64'h0000_0005);
        chk("after_abort_lat", 64'(lat), 64'd5);

        // Result holds while idle with inputs wiggling.
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            a = a + 32'h0101_0101;
            b = b ^ 32'hA5A5_A5A5;
            if (sum !== 32'h0000_0005 || cout !== 1'b0 || done !== 1'b0)
                hold_bad++;
        end
        chk("hold_stable", 64'(hold_bad), 64'd0);

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
        sub = 1'b1;
        do_op(32'h0000_0007, 32'h0000_0005, lat, bcnt);
        chk("sub_pos_sum", 64'(sum), 64'h0000_0002);
        chk("sub_pos_cout", 64'(cout), 64'd1);
        tick();
        do_op(32'h0000_0005, 32'h0000_0007, lat, bcnt);
        chk("sub_neg_sum", 64'(sum), 64'hFFFF_FFFE);
        chk("sub_neg_cout", 64'(cout), 64'd0);
        tick();
        sub = 1'b0;
        do_op(32'h0000_0007, 32'h0000_0005, lat, bcnt);
        chk("sub0_add_sum", 64'(sum), 64'h0000_000C);
        chk("sub0_add_cout", 64'(cout), 64'd0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
